// File: rtl/tlb_lookup_pipe.sv
// Pipelined multi-channel TLB lookup.
// Each channel has two stages. S1 compares the request against every entry
// and registers the match vector. S2 picks the lowest-index winner, selects
// the odd or even page, builds the physical address and sets the exception code.
// All channels share the entry array and the flush strobe.

package tlb_pkg;
  localparam int TLB_ENTRIES_NUM = 16;
  localparam int TLB_INDEX_BITS  = 4;

  // Compare section: VPN2 = vaddr[31:13]; pagemask covers vpn2[15:0]
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [15:0] pagemask;
    logic        g;
  } tlb_compsec_t;

  // Translate section: even (0) and odd (1) page of the pair
  typedef struct packed {
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_transec_t;

  typedef struct packed {
    tlb_compsec_t compsec;
    tlb_transec_t transec;
  } tlb_entry_t;
endpackage

module tlb_lookup_pipe
  import tlb_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int ENTRIES       = TLB_ENTRIES_NUM,
  parameter bit IDX_FORCE_MSB = 1'b0,
  parameter bit STORE_CHECK   = 1'b1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  tlb_entry_t                          entries [ENTRIES],
  input  logic                                flush,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS*32-1:0]             req_vaddr,
  input  logic [NUM_PORTS*8-1:0]              req_asid,
  input  logic [NUM_PORTS-1:0]                req_store,
  output logic [NUM_PORTS-1:0]                resp_valid,
  input  logic [NUM_PORTS-1:0]                resp_ready,
  output logic [NUM_PORTS*32-1:0]             resp_paddr,
  output logic [NUM_PORTS*TLB_INDEX_BITS-1:0] resp_idx,
  output logic [NUM_PORTS*2-1:0]              resp_excp,
  output logic [NUM_PORTS-1:0]                resp_multihit,
  output logic [NUM_PORTS*3-1:0]              resp_cached
);

  // Only contiguous low-order bit-pair masks describe a real page size
  function automatic logic pm_legal(input logic [15:0] pm);
    case (pm)
      16'h0000, 16'h0003, 16'h000F, 16'h003F, 16'h00FF,
      16'h03FF, 16'h0FFF, 16'h3FFF, 16'hFFFF: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Number of bit-pairs set: page size is 4K * 4^k
  function automatic logic [3:0] pm_k(input logic [15:0] pm);
    case (pm)
      16'h0003: return 4'd1;
      16'h000F: return 4'd2;
      16'h003F: return 4'd3;
      16'h00FF: return 4'd4;
      16'h03FF: return 4'd5;
      16'h0FFF: return 4'd6;
      16'h3FFF: return 4'd7;
      16'hFFFF: return 4'd8;
      default:  return 4'd0;
    endcase
  endfunction

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ch
    logic [31:0] vaddr_in;
    logic [7:0]  asid_in;
    assign vaddr_in = req_vaddr[gi*32 +: 32];
    assign asid_in  = req_asid[gi*8 +: 8];

    logic                      s1_valid_reg;
    logic [ENTRIES-1:0]        s1_match_reg;
    logic [31:0]               s1_vaddr_reg;
    logic                      s1_store_reg;
    logic [15:0]               s1_pm_reg;
    logic                      s2_valid_reg;
    logic [31:0]               s2_paddr_reg;
    logic [TLB_INDEX_BITS-1:0] s2_idx_reg;
    logic [1:0]                s2_excp_reg;
    logic                      s2_multihit_reg;
    logic [2:0]                s2_cached_reg;

    logic s2_free, s1_adv, accept;
    assign s2_free        = !s2_valid_reg || resp_ready[gi];
    assign s1_adv         = s1_valid_reg && s2_free;
    assign req_ready[gi]  = !s1_valid_reg || s1_adv;
    assign accept         = req_valid[gi] && req_ready[gi];

    logic [ENTRIES-1:0] match_comb;
    logic [15:0]        pm_comb;

    // S1 compare: every legal entry hit, pagemask of the lowest-index hit
    always_comb begin
      match_comb = '0;
      pm_comb    = '0;
      for (int e = ENTRIES - 1; e >= 0; e--) begin
        if (pm_legal(entries[e].compsec.pagemask)
            && (entries[e].compsec.vpn2[18:16] == vaddr_in[31:29])
            && (((entries[e].compsec.vpn2[15:0] ^ vaddr_in[28:13])
                 & ~entries[e].compsec.pagemask) == 16'h0000)
            && (entries[e].compsec.g || (entries[e].compsec.asid == asid_in))) begin
          match_comb[e] = 1'b1;
          pm_comb       = entries[e].compsec.pagemask;
        end
      end
    end

    logic [TLB_INDEX_BITS-1:0] win_idx;
    tlb_transec_t              win_te;
    logic [4:0]                sel_pos;
    logic [31:0]               off_mask;
    logic                      odd;
    logic [19:0]               pfn;
    logic                      pg_v, pg_d;
    logic [2:0]                pg_c;
    logic [31:0]               paddr_comb;
    logic [TLB_INDEX_BITS-1:0] idx_comb;
    logic [1:0]                excp_comb;
    logic                      multihit_comb;
    logic [2:0]                cached_comb;

    // S2 select/translate: lowest-index winner, odd/even page, exception priority
    always_comb begin
      win_idx = '0;
      for (int e = ENTRIES - 1; e >= 0; e--) begin
        if (s1_match_reg[e]) win_idx = TLB_INDEX_BITS'(e);
      end
      win_te   = entries[win_idx].transec;
      sel_pos  = 5'd12 + {pm_k(s1_pm_reg), 1'b0};
      off_mask = (32'h1 << sel_pos) - 32'h1;
      odd      = s1_vaddr_reg[sel_pos];
      pfn      = odd ? win_te.pfn1 : win_te.pfn0;
      pg_v     = odd ? win_te.v1   : win_te.v0;
      pg_d     = odd ? win_te.d1   : win_te.d0;
      pg_c     = odd ? win_te.c1   : win_te.c0;
      multihit_comb = ($countones(s1_match_reg) > 1);

      paddr_comb  = s1_vaddr_reg;
      idx_comb    = '0;
      excp_comb   = 2'b01;
      cached_comb = 3'd0;
      if (s1_match_reg != '0) begin
        paddr_comb  = ({pfn, 12'h000} & ~off_mask) | (s1_vaddr_reg & off_mask);
        idx_comb    = win_idx;
        if (IDX_FORCE_MSB) idx_comb[TLB_INDEX_BITS-1] = 1'b1;
        cached_comb = pg_c;
        if (!pg_v)                                   excp_comb = 2'b10;
        else if (STORE_CHECK && s1_store_reg && !pg_d) excp_comb = 2'b11;
        else                                         excp_comb = 2'b00;
      end
    end

    // Pipeline registers: flush beats accept/advance, a stalled S2 holds its payload
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s1_valid_reg    <= 1'b0;
        s1_match_reg    <= '0;
        s1_vaddr_reg    <= '0;
        s1_store_reg    <= 1'b0;
        s1_pm_reg       <= '0;
        s2_valid_reg    <= 1'b0;
        s2_paddr_reg    <= '0;
        s2_idx_reg      <= '0;
        s2_excp_reg     <= '0;
        s2_multihit_reg <= 1'b0;
        s2_cached_reg   <= '0;
      end else if (flush) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
      end else begin
        if (accept) begin
          s1_valid_reg <= 1'b1;
          s1_match_reg <= match_comb;
          s1_vaddr_reg <= vaddr_in;
          s1_store_reg <= req_store[gi];
          s1_pm_reg    <= pm_comb;
        end else if (s1_adv) begin
          s1_valid_reg <= 1'b0;
        end
        if (s1_adv) begin
          s2_valid_reg    <= 1'b1;
          s2_paddr_reg    <= paddr_comb;
          s2_idx_reg      <= idx_comb;
          s2_excp_reg     <= excp_comb;
          s2_multihit_reg <= multihit_comb;
          s2_cached_reg   <= cached_comb;
        end else if (resp_ready[gi]) begin
          s2_valid_reg <= 1'b0;
        end
      end
    end

    assign resp_valid[gi]                              = s2_valid_reg;
    assign resp_paddr[gi*32 +: 32]                     = s2_paddr_reg;
    assign resp_idx[gi*TLB_INDEX_BITS +: TLB_INDEX_BITS] = s2_idx_reg;
    assign resp_excp[gi*2 +: 2]                        = s2_excp_reg;
    assign resp_multihit[gi]                           = s2_multihit_reg;
    assign resp_cached[gi*3 +: 3]                      = s2_cached_reg;
  end

endmodule

// File: tb/tb_tlb_lookup_pipe.sv
// Directed bench for tlb_lookup_pipe: hits, large pages, exceptions,
// multi-hit, backpressure, flush and asynchronous reset.
module tb_tlb_lookup_pipe;
  import tlb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  tlb_entry_t  ents [TLB_ENTRIES_NUM];
  logic        flush;
  logic [1:0]  req_valid, req_ready, req_store;
  logic [63:0] req_vaddr;
  logic [15:0] req_asid;
  logic [1:0]  resp_valid, resp_ready, resp_multihit;
  logic [63:0] resp_paddr;
  logic [7:0]  resp_idx;
  logic [3:0]  resp_excp;
  logic [5:0]  resp_cached;
  // Second instance without store checking, same stimulus
  logic [1:0]  req_ready_nc, resp_valid_nc, resp_multihit_nc;
  logic [63:0] resp_paddr_nc;
  logic [7:0]  resp_idx_nc;
  logic [3:0]  resp_excp_nc;
  logic [5:0]  resp_cached_nc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tlb_lookup_pipe #(.NUM_PORTS(2), .ENTRIES(TLB_ENTRIES_NUM), .IDX_FORCE_MSB(1'b0), .STORE_CHECK(1'b1)) dut (
    .clk(clk), .resetn(resetn), .entries(ents), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_asid(req_asid), .req_store(req_store), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_paddr(resp_paddr), .resp_idx(resp_idx),
    .resp_excp(resp_excp), .resp_multihit(resp_multihit), .resp_cached(resp_cached)
  );

  tlb_lookup_pipe #(.NUM_PORTS(2), .ENTRIES(TLB_ENTRIES_NUM), .IDX_FORCE_MSB(1'b0), .STORE_CHECK(1'b0)) dut_nc (
    .clk(clk), .resetn(resetn), .entries(ents), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready_nc), .req_vaddr(req_vaddr),
    .req_asid(req_asid), .req_store(req_store), .resp_valid(resp_valid_nc),
    .resp_ready(resp_ready), .resp_paddr(resp_paddr_nc), .resp_idx(resp_idx_nc),
    .resp_excp(resp_excp_nc), .resp_multihit(resp_multihit_nc), .resp_cached(resp_cached_nc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ent(input int i, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic [15:0] pm, input logic g,
                         input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                         input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    ents[i].compsec = '{vpn2: vpn2, asid: asid, pagemask: pm, g: g};
    ents[i].transec = '{pfn0: pfn0, c0: c0, d0: d0, v0: v0, pfn1: pfn1, c1: c1, d1: d1, v1: v1};
  endtask

  task automatic set_req(input int ch, input logic [31:0] va, input logic [7:0] asid, input logic st);
    req_valid[ch]          = 1'b1;
    req_vaddr[ch*32 +: 32] = va;
    req_asid[ch*8 +: 8]    = asid;
    req_store[ch]          = st;
  endtask

  task automatic chk_resp(input int ch, input string tag, input logic [31:0] pa, input logic [31:0] idx,
                          input logic [31:0] ex, input logic [31:0] mh, input logic [31:0] c);
    check({tag, ".valid"}, 32'(resp_valid[ch]), 1);
    check({tag, ".paddr"}, resp_paddr[ch*32 +: 32], pa);
    check({tag, ".idx"}, 32'(resp_idx[ch*4 +: 4]), idx);
    check({tag, ".excp"}, 32'(resp_excp[ch*2 +: 2]), ex);
    check({tag, ".mhit"}, 32'(resp_multihit[ch]), mh);
    check({tag, ".cached"}, 32'(resp_cached[ch*3 +: 3]), c);
    $display("lookup %s ch%0d pa=%h idx=%0d excp=%0d mh=%0d", tag, ch,
             resp_paddr[ch*32 +: 32], resp_idx[ch*4 +: 4], resp_excp[ch*2 +: 2], resp_multihit[ch]);
  endtask

  // One request on one channel, response expected two edges later
  task automatic lookup(input int ch, input string tag, input logic [31:0] va, input logic [7:0] asid,
                        input logic st, input logic [31:0] pa, input logic [31:0] idx,
                        input logic [31:0] ex, input logic [31:0] mh, input logic [31:0] c);
    resp_ready = 2'b11;
    set_req(ch, va, asid, st);
    tick();
    req_valid = 2'b00;
    check({tag, ".lat1"}, 32'(resp_valid[ch]), 0);
    tick();
    chk_resp(ch, tag, pa, idx, ex, mh, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, first_c, last_c;
    logic [31:0] held, pa;
    logic acc, cons;

    resetn = 1'b0; flush = 1'b0;
    req_valid = '0; req_store = '0; req_vaddr = '0; req_asid = '0; resp_ready = '0;
    for (int i = 0; i < TLB_ENTRIES_NUM; i++)
      set_ent(i, 19'h7FFFF, 8'h00, 16'h0000, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
    set_ent(3,  19'h00401, 8'h05, 16'h0000, 1'b0, 20'h0FFFF, 3'd1, 1'b1, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1);
    set_ent(7,  19'h09100, 8'h11, 16'h00FF, 1'b1, 20'h11111, 3'd2, 1'b1, 1'b1, 20'hABCDE, 3'd6, 1'b1, 1'b1);
    set_ent(4,  19'h00200, 8'h06, 16'h0000, 1'b0, 20'h00ABC, 3'd2, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    set_ent(5,  19'h00300, 8'h06, 16'h0000, 1'b0, 20'h00DEF, 3'd1, 1'b1, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
    set_ent(2,  19'h00500, 8'h00, 16'h0000, 1'b1, 20'h22222, 3'd4, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    set_ent(9,  19'h00500, 8'h01, 16'h0000, 1'b0, 20'h99999, 3'd7, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    set_ent(10, 19'h00600, 8'h00, 16'h0001, 1'b1, 20'h33333, 3'd1, 1'b1, 1'b1, 20'h33333, 3'd1, 1'b1, 1'b1);
    set_ent(11, 19'h10000, 8'h00, 16'hFFFF, 1'b1, 20'hF0000, 3'd5, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);

    // Reset state
    tick();
    check("rst.valid", 32'(resp_valid), 0);
    check("rst.ready", 32'(req_ready), 3);
    check("rst.paddr", resp_paddr[31:0], 0);
    @(negedge clk); resetn = 1'b1;
    tick();

    // T1 on channel 1, T2 on channel 0
    lookup(1, "t1.hit4k", 32'h00803ABC, 8'h05, 1'b0, 32'h12345ABC, 3, 0, 0, 3);
    lookup(0, "t2.large", 32'h12345678, 8'h22, 1'b0, 32'hABC45678, 7, 0, 0, 6);
    lookup(0, "pm.max",   32'h2ABCDEF0, 8'h09, 1'b0, 32'hFABCDEF0, 11, 0, 0, 5);
    lookup(0, "pm.illegal", 32'h00C00000, 8'h00, 1'b0, 32'h00C00000, 0, 1, 0, 0);

    // T3 exceptions
    lookup(0, "t3.miss",  32'h00400123, 8'h07, 1'b0, 32'h00400123, 0, 1, 0, 0);
    lookup(0, "t3.inval", 32'h00600010, 8'h06, 1'b0, 32'h00DEF010, 5, 2, 0, 1);
    lookup(0, "t3.mod",   32'h00400456, 8'h06, 1'b1, 32'h00ABC456, 4, 3, 0, 2);
    check("t3.nochk.excp", 32'(resp_excp_nc[1:0]), 0);
    check("t3.nochk.paddr", resp_paddr_nc[31:0], 32'h00ABC456);
    lookup(0, "t3.load",  32'h00400456, 8'h06, 1'b0, 32'h00ABC456, 4, 0, 0, 2);

    // T4 multi-hit on ch0 in parallel with a T1 hit on ch1
    resp_ready = 2'b11;
    set_req(0, 32'h00A00000, 8'h01, 1'b0);
    set_req(1, 32'h00803ABC, 8'h05, 1'b0);
    tick();
    req_valid = 2'b00;
    tick();
    chk_resp(0, "t4.multi", 32'h22222000, 2, 0, 1, 4);
    chk_resp(1, "t4.par1", 32'h12345ABC, 3, 0, 0, 3);
    lookup(0, "t4.single", 32'h00A00000, 8'h03, 1'b0, 32'h22222000, 2, 0, 0, 4);
    tick();

    // T5 backpressure: six back-to-back requests, resp_ready low for three cycles
    sent = 0; rcv = 0; first_c = -1; last_c = -1; held = '0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      resp_ready[0] = (c >= 3);
      req_valid[0]  = (sent < 6);
      req_vaddr[31:0] = 32'h00803000 + 32'(sent * 16);
      req_asid[7:0] = 8'h05;
      req_store[0]  = 1'b0;
      #3;
      if (c == 2) begin
        check("t5.ready_drop", 32'(req_ready[0]), 0);
        check("t5.accepted", 32'(sent), 2);
        check("t5.stall_valid", 32'(resp_valid[0]), 1);
        held = resp_paddr[31:0];
      end
      if (c == 3) check("t5.hold", resp_paddr[31:0], held);
      acc  = req_valid[0] & req_ready[0];
      cons = resp_valid[0] & resp_ready[0];
      pa   = resp_paddr[31:0];
      if (cons) begin
        check($sformatf("t5.pa%0d", rcv), pa, 32'h12345000 + 32'(rcv * 16));
        $display("stream rsp %0d cycle %0d pa=%h", rcv, c, pa);
        if (first_c < 0) first_c = c;
        last_c = c;
        rcv++;
      end
      if (acc) sent++;
      tick();
    end
    req_valid = 2'b00;
    check("t5.rcv", 32'(rcv), 6);
    check("t5.sent", 32'(sent), 6);
    check("t5.rate", 32'(last_c - first_c), 5);
    tick();
    check("t5.no_extra", 32'(resp_valid[0]), 0);

    // T6 flush with two in flight on ch0; ch1 accepts in the flush cycle
    resp_ready = 2'b00;
    set_req(0, 32'h00803100, 8'h05, 1'b0);
    tick();
    set_req(0, 32'h00803200, 8'h05, 1'b0);
    tick();
    check("t6.inflight", 32'(resp_valid[0]), 1);
    check("t6.inflight_pa", resp_paddr[31:0], 32'h12345100);
    req_valid = 2'b00;
    resp_ready = 2'b10;
    set_req(1, 32'h00803ABC, 8'h05, 1'b0);
    flush = 1'b1;
    #3;
    check("t6.ch1_ready", 32'(req_ready[1]), 1);
    tick();
    flush = 1'b0;
    req_valid = 2'b00;
    check("t6.flushed", 32'(resp_valid), 0);
    check("t6.ready", 32'(req_ready), 3);
    resp_ready = 2'b11;
    tick();
    check("t6.dropped", 32'(resp_valid), 0);
    lookup(0, "t6.reissue", 32'h00803200, 8'h05, 1'b0, 32'h12345200, 3, 0, 0, 3);
    tick();

    // Reset pulse mid-stream
    resp_ready = 2'b00;
    set_req(0, 32'h00803300, 8'h05, 1'b0);
    tick();
    set_req(0, 32'h00803400, 8'h05, 1'b0);
    tick();
    check("rst2.pre_valid", 32'(resp_valid[0]), 1);
    check("rst2.pre_pa", resp_paddr[31:0], 32'h12345300);
    #2;
    resetn = 1'b0;
    #1;
    check("rst2.valid", 32'(resp_valid), 0);
    check("rst2.paddr", resp_paddr[31:0], 0);
    check("rst2.idx", 32'(resp_idx), 0);
    check("rst2.ready", 32'(req_ready), 3);
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("rst2.post_valid", 32'(resp_valid), 0);
    check("rst2.post_ready", 32'(req_ready), 3);
    lookup(1, "rst2.again", 32'h00803ABC, 8'h05, 1'b0, 32'h12345ABC, 3, 0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
